// File: rtl/instr_fetch_unit_if.sv
// Bundle for the fetch unit. It groups the instruction-memory request and
// response signals, the decode-side valid/ready pair with its payload, and
// the redirect inputs coming back from execute.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    // instruction memory request / response
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    // toward decode
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [6:0]      op;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] instr_pc_plus4;

    // from execute
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    // fetch unit side
    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instr,
        output op,
        output instr_pc,
        output instr_pc_plus4,
        input  instr_ready,
        input  redirect,
        input  redirect_target
    );

    // memory / decode / execute side
    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instr,
        input  op,
        input  instr_pc,
        input  instr_pc_plus4,
        output instr_ready,
        output redirect,
        output redirect_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end. Holds the PC, keeps at most one request
// outstanding to instruction memory, buffers the returned word for decode,
// and squashes wrong-path fetches when execute redirects the PC.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_fetch_unit_if.master     bus
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,  // issue a request for pc
        ST_WAIT = 2'd1,  // one request outstanding
        ST_HOLD = 2'd2   // instruction buffered toward decode
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;

    logic [XLEN-1:0] target_aligned;

    // Redirect targets are always word aligned; low two bits are dropped.
    assign target_aligned = {bus.redirect_target[XLEN-1:2], 2'b00};

    // A redirect in REQ suppresses the request so the stale pc never goes out.
    assign bus.imem_req_valid = (state_q == ST_REQ) & ~bus.redirect & rst_n;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.instr          = instr_q;
    assign bus.op             = instr_q[6:0];
    assign bus.instr_pc       = instr_pc_q;
    assign bus.instr_pc_plus4 = instr_pc_q + PC_STEP;

    // Next-state logic: fetch sequencing, response capture and redirect handling.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;

        unique case (state_q)
            ST_REQ: begin
                if (bus.redirect) begin
                    pc_d = target_aligned;
                end else if (bus.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (!kill_q && !bus.redirect) begin
                        instr_d       = bus.imem_rsp_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end else begin
                        // Wrong-path response: drop it and refetch from pc.
                        if (bus.redirect) begin
                            pc_d = target_aligned;
                        end
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end
                end else if (bus.redirect) begin
                    // Request still in flight; remember to discard its data.
                    pc_d   = target_aligned;
                    kill_d = 1'b1;
                end
            end

            ST_HOLD: begin
                if (bus.redirect) begin
                    pc_d          = target_aligned;
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                end else if (bus.instr_ready) begin
                    pc_d          = pc_q + PC_STEP;
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the RISC-V core; sits directly upstream of the main decoder.
- Holds the PC and issues one request at a time to a handshaked instruction memory.
- Buffers the returned instruction and presents instr/op to decode with a valid/ready pair.
- Accepts branch/jal redirects from execute and squashes any wrong-path fetch.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  XLEN  fetch address; always equals pc.
- imem_rsp_valid  in  1  response data valid; at most one per accepted request.
- imem_rsp_data  in  XLEN  fetched instruction word.
- instr_valid  out  1  instr/op/instr_pc valid toward decode.
- instr_ready  in  1  decode/execute consumes the instruction this cycle.
- instr  out  XLEN  buffered instruction word.
- op  out  7  instr[6:0]; drives the main decoder opcode input.
- instr_pc  out  XLEN  PC of the buffered instruction.
- instr_pc_plus4  out  XLEN  instr_pc + 4, modulo 2^XLEN; used for the jal link value.
- redirect  in  1  taken branch or jal (pc_src).
- redirect_target  in  XLEN  new PC; bits [1:0] forced to 0 internally.

Behaviour:
- Reset (rst_n=0 at an edge): pc=RESET_PC, state=REQ, kill=0, instr_valid=0, instr/instr_pc=0. imem_req_valid=0 while rst_n=0.
- States:
  - REQ (issue).
  - WAIT (one request outstanding).
  - HOLD (instruction buffered).
- Only one request is ever outstanding.
- imem_req_valid = (state==REQ) & ~redirect & rst_n. This is combinational from state, so a redirect in REQ suppresses the request.
- REQ:
  - redirect: pc<=target, stay REQ.
  - Else if imem_req_ready: go to WAIT.
  - Else: hold; imem_addr stays stable.
- WAIT:
  - rsp_valid & ~kill & ~redirect: instr<=rsp_data, instr_pc<=pc, instr_valid<=1, go to HOLD.
  - rsp_valid & (kill | redirect): discard data; pc<=target if redirect, else keep; kill<=0; go to REQ.
  - redirect without rsp_valid: pc<=target, kill<=1, stay WAIT.
  - A second redirect while kill=1 overwrites pc; the last redirect wins.
- HOLD:
  - instr_ready & ~redirect: pc<=pc+4, instr_valid<=0, go to REQ.
  - redirect (with or without instr_ready): pc<=target, instr_valid<=0, go to REQ. If instr_ready is low, the buffered instruction is squashed.
  - Neither: hold all outputs stable.
- Latency: minimum 3 cycles from REQ handshake to the next REQ with a 1-cycle memory:
  - request accepted at edge N;
  - response captured at edge N+1;
  - consumed at edge N+2.
- PC arithmetic is modulo 2^XLEN; 0xFFFF_FFFC + 4 wraps to 0.
- instr_valid never asserts for a killed response.
- A rsp_valid arriving in REQ or HOLD is a protocol error and is ignored.
- Reset mid-operation: all state returns to reset values on the next edge, including kill. A response arriving after reset is released and before the first request is ignored.

Test Plan:
- Reset then 1-cycle memory returning 0x0000_0093 at address 0, instr_ready=1 → imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses with op=0x13, instr_pc=0x0, instr_pc_plus4=0x4.
- imem_req_ready held low for 5 cycles in REQ → imem_req_valid=1 and imem_addr=0x0 stable for all 5 cycles; no state change.
- In HOLD at instr_pc=0x10, hold instr_ready=0 for 3 cycles, then assert it → outputs stable, then next imem_addr=0x14.
- In WAIT at pc=0x20, redirect to 0x103 with no response; response 0xDEAD_BEEF arrives 2 cycles later → response discarded (instr_valid stays 0); next request at imem_addr=0x100.
- In HOLD, instr_ready=1 and redirect=1 with target 0x40 in the same cycle → next imem_addr=0x40, not instr_pc+4.
- With pc=0xFFFF_FFFC, consume the instruction → next imem_addr=0x0 (wrap). Then assert rst_n=0 during WAIT → the next cycle after release shows imem_addr=RESET_PC, and the stale response is ignored.
